// File: rtl/mouse_cdc_pkg.sv
// Shared types for the mouse-position clock-domain crossing (transmitter and receiver).
package mouse_cdc_pkg;

    localparam int POS_W = 12;

    typedef enum logic {IDLE, WAIT_ACK} cdc_tx_state_t;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
    } pos_t;

endpackage

// File: rtl/cdc_bit_sync.sv
// Single-bit N-flop synchroniser with asynchronous active-low reset.
module cdc_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/mouse_pos_cdc_tx.sv
// Source-side mouse position launcher: freezes a sample on the launch bus, announces it with
// a request toggle and holds it until the synchronised acknowledge toggle catches up.
module mouse_pos_cdc_tx
    import mouse_cdc_pkg::*;
#(
    parameter int W           = POS_W,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     xpos_in,
    input  logic [W-1:0]     ypos_in,
    input  logic             pos_valid,
    output logic [W-1:0]     xpos_tx,
    output logic [W-1:0]     ypos_tx,
    output logic             req_tgl,
    input  logic             ack_tgl,
    output logic             busy,
    output logic [CNT_W-1:0] overrun_cnt
);

    cdc_tx_state_t    r_state, w_state;
    logic [W-1:0]     r_x_tx, r_y_tx, w_x_tx, w_y_tx;
    logic [W-1:0]     r_pend_x, r_pend_y, w_pend_x, w_pend_y;
    logic             r_pend_valid, w_pend_valid;
    logic             r_req, w_req;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             w_ack_s;
    logic             w_done;

    cdc_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (ack_tgl),
        .o_q   (w_ack_s)
    );

    // Acks seen while IDLE are stale or spurious and must not complete anything.
    assign w_done = (r_state == WAIT_ACK) && (w_ack_s == r_req);

    always_comb begin
        w_state      = r_state;
        w_x_tx       = r_x_tx;
        w_y_tx       = r_y_tx;
        w_req        = r_req;
        w_pend_x     = r_pend_x;
        w_pend_y     = r_pend_y;
        w_pend_valid = r_pend_valid;
        w_cnt        = r_cnt;
        case (r_state)
            IDLE: begin
                if (pos_valid) begin
                    w_x_tx  = xpos_in;
                    w_y_tx  = ypos_in;
                    w_req   = ~r_req;
                    w_state = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (w_done) begin
                    if (r_pend_valid) begin
                        w_x_tx = r_pend_x;
                        w_y_tx = r_pend_y;
                        w_req  = ~r_req;
                        // A sample arriving alongside the pending launch refills the slot.
                        if (pos_valid) begin
                            w_pend_x = xpos_in;
                            w_pend_y = ypos_in;
                        end else begin
                            w_pend_valid = 1'b0;
                        end
                    end else if (pos_valid) begin
                        w_x_tx = xpos_in;
                        w_y_tx = ypos_in;
                        w_req  = ~r_req;
                    end else begin
                        w_state = IDLE;
                    end
                end else if (pos_valid) begin
                    w_pend_x     = xpos_in;
                    w_pend_y     = ypos_in;
                    w_pend_valid = 1'b1;
                    if (r_pend_valid && !(&r_cnt)) begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_x_tx       <= '0;
            r_y_tx       <= '0;
            r_req        <= 1'b0;
            r_pend_x     <= '0;
            r_pend_y     <= '0;
            r_pend_valid <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_x_tx       <= w_x_tx;
            r_y_tx       <= w_y_tx;
            r_req        <= w_req;
            r_pend_x     <= w_pend_x;
            r_pend_y     <= w_pend_y;
            r_pend_valid <= w_pend_valid;
            r_cnt        <= w_cnt;
            r_busy       <= (w_state == WAIT_ACK);
        end
    end

    assign xpos_tx     = r_x_tx;
    assign ypos_tx     = r_y_tx;
    assign req_tgl     = r_req;
    assign busy        = r_busy;
    assign overrun_cnt = r_cnt;

endmodule

// File: tb/tb_mouse_pos_cdc_tx.sv
// Directed bench for mouse_pos_cdc_tx; a narrow-counter copy shares the stimulus for saturation.
module tb_mouse_pos_cdc_tx;

    localparam int W  = 12;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] xin, yin;
    logic         pv, ack;

    logic [W-1:0] xpos_tx, ypos_tx, s_xpos_tx, s_ypos_tx;
    logic         req_tgl, busy, s_req_tgl, s_busy;
    logic [7:0]   overrun_cnt;
    logic [1:0]   s_overrun_cnt;

    logic [2*W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    logic prev_req = 1'b0;
    logic prev_rst = 1'b0;

    always #5 clk = ~clk;

    mouse_pos_cdc_tx #(.W(W), .SYNC_STAGES(SS), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .xpos_in(xin), .ypos_in(yin), .pos_valid(pv),
        .xpos_tx(xpos_tx), .ypos_tx(ypos_tx), .req_tgl(req_tgl), .ack_tgl(ack),
        .busy(busy), .overrun_cnt(overrun_cnt)
    );

    mouse_pos_cdc_tx #(.W(W), .SYNC_STAGES(SS), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .xpos_in(xin), .ypos_in(yin), .pos_valid(pv),
        .xpos_tx(s_xpos_tx), .ypos_tx(s_ypos_tx), .req_tgl(s_req_tgl), .ack_tgl(ack),
        .busy(s_busy), .overrun_cnt(s_overrun_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [W-1:0] x, input logic [W-1:0] y);
        pv  = 1'b1;
        xin = x;
        yin = y;
        tick();
        pv  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idle_busy", {31'd0, busy}, 32'd0);
    endtask

    // Every request edge must carry the oldest still-expected sample.
    always @(negedge clk) begin
        if (rst_n && prev_rst && (req_tgl !== prev_req)) begin
            if (exp_q.size() == 0) begin
                chk("launch_unexpected", {20'd0, xpos_tx}, 32'hFFFF_FFFF);
            end else begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                chk("launch_x", {20'd0, xpos_tx}, {20'd0, e[2*W-1:W]});
                chk("launch_y", {20'd0, ypos_tx}, {20'd0, e[W-1:0]});
                chk("launch_sat_x", {20'd0, s_xpos_tx}, {20'd0, e[2*W-1:W]});
            end
        end
        prev_req = req_tgl;
        prev_rst = rst_n;
    end

    initial begin
        rst_n = 1'b0;
        pv    = 1'b1;
        xin   = 12'hABC;
        yin   = 12'hDEF;
        ack   = 1'b0;
        repeat (3) tick();
        chk("rst_x", {20'd0, xpos_tx}, 32'd0);
        chk("rst_y", {20'd0, ypos_tx}, 32'd0);
        chk("rst_req", {31'd0, req_tgl}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {24'd0, overrun_cnt}, 32'd0);
        pv    = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_req", {31'd0, req_tgl}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Single transfer with timed acknowledge
        exp_q.push_back({12'h123, 12'h045});
        strobe(12'h123, 12'h045);
        chk("single_x", {20'd0, xpos_tx}, 32'h123);
        chk("single_y", {20'd0, ypos_tx}, 32'h045);
        chk("single_req", {31'd0, req_tgl}, 32'd1);
        chk("single_busy", {31'd0, busy}, 32'd1);
        repeat (3) tick();
        ack = 1'b1;
        for (int i = 0; i < SS; i++) begin
            tick();
            chk("single_busy_hold", {31'd0, busy}, 32'd1);
        end
        tick();
        chk("single_busy_clear", {31'd0, busy}, 32'd0);
        chk("single_req_hold", {31'd0, req_tgl}, 32'd1);

        // Coalescing: newest of three strobes wins
        exp_q.push_back({12'h005, 12'h005});
        strobe(12'h005, 12'h005);
        strobe(12'h010, 12'h010);
        strobe(12'h020, 12'h020);
        strobe(12'h030, 12'h030);
        exp_q.push_back({12'h030, 12'h030});
        chk("coal_cnt", {24'd0, overrun_cnt}, 32'd2);
        chk("coal_sat_cnt", {30'd0, s_overrun_cnt}, 32'd2);
        chk("coal_frozen_x", {20'd0, xpos_tx}, 32'h005);
        chk("coal_frozen_req", {31'd0, req_tgl}, 32'd0);
        ack = 1'b0;
        repeat (SS + 1) tick();
        chk("coal_launch_x", {20'd0, xpos_tx}, 32'h030);
        chk("coal_launch_req", {31'd0, req_tgl}, 32'd1);
        chk("coal_launch_busy", {31'd0, busy}, 32'd1);
        ack = 1'b1;
        wait_idle(20);

        // Strobe coinciding with completion while a sample is pending
        exp_q.push_back({12'h010, 12'h010});
        strobe(12'h010, 12'h010);
        strobe(12'h020, 12'h020);
        ack = 1'b0;
        repeat (SS) tick();
        exp_q.push_back({12'h020, 12'h020});
        exp_q.push_back({12'h030, 12'h030});
        strobe(12'h030, 12'h030);
        chk("simul_x", {20'd0, xpos_tx}, 32'h020);
        chk("simul_req", {31'd0, req_tgl}, 32'd1);
        chk("simul_cnt", {24'd0, overrun_cnt}, 32'd2);
        ack = 1'b1;
        repeat (SS + 1) tick();
        chk("simul_next_x", {20'd0, xpos_tx}, 32'h030);
        chk("simul_next_req", {31'd0, req_tgl}, 32'd0);
        chk("simul_next_busy", {31'd0, busy}, 32'd1);
        ack = 1'b0;
        wait_idle(20);

        // Saturation: narrow counter stops at all-ones
        exp_q.push_back({12'h100, 12'h100});
        strobe(12'h100, 12'h100);
        for (int i = 0; i < 6; i++) strobe(12'h101 + 12'(i), 12'h055);
        chk("sat_wide_cnt", {24'd0, overrun_cnt}, 32'd7);
        chk("sat_narrow_cnt", {30'd0, s_overrun_cnt}, 32'd3);
        strobe(12'h107, 12'h077);
        exp_q.push_back({12'h107, 12'h077});
        chk("sat_wide_cnt2", {24'd0, overrun_cnt}, 32'd8);
        chk("sat_narrow_hold", {30'd0, s_overrun_cnt}, 32'd3);
        ack = 1'b1;
        repeat (SS + 1) tick();
        chk("sat_launch_x", {20'd0, xpos_tx}, 32'h107);
        chk("sat_launch_y", {20'd0, ypos_tx}, 32'h077);
        ack = 1'b0;
        wait_idle(20);

        // Asynchronous reset with a transfer outstanding and a sample pending
        exp_q.push_back({12'h200, 12'h200});
        strobe(12'h200, 12'h200);
        strobe(12'h201, 12'h201);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_x", {20'd0, xpos_tx}, 32'd0);
        chk("arst_req", {31'd0, req_tgl}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_cnt", {24'd0, overrun_cnt}, 32'd0);
        chk("arst_sat_cnt", {30'd0, s_overrun_cnt}, 32'd0);
        ack = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("arst_no_stale_req", {31'd0, req_tgl}, 32'd0);
        chk("arst_no_stale_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back({12'h300, 12'h301});
        strobe(12'h300, 12'h301);
        chk("arst_new_req", {31'd0, req_tgl}, 32'd1);
        chk("arst_new_x", {20'd0, xpos_tx}, 32'h300);
        ack = 1'b1;
        wait_idle(20);

        repeat (2) tick();
        chk("exp_q_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
